// File: rtl/cnn_filter_pkg.sv
// cnn_filter_pkg: shared filter sizing constants and loader state encoding
package cnn_filter_pkg;
  localparam int NUM_TAPS = 9;
  localparam int FILTER_WORDS = 10;
  localparam int WEIGHT_W = 16;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
endpackage

// File: rtl/filter_reg_bank.sv
// filter_reg_bank: single-write-port register file with full-width registered read
module filter_reg_bank
  import cnn_filter_pkg::*;
#(
  parameter int W = WEIGHT_W,
  parameter int N = FILTER_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [3:0]          waddr,
  input  logic [W-1:0]        wdata,
  input  logic                en,
  output logic [N-1:0][W-1:0] rd
);
  logic [N-1:0][W-1:0] mem;
  // storage: one word written per cycle, cleared by reset
  always_ff @(posedge clk)
    if (rst) mem <= '0;
    else if (we) mem[waddr] <= wdata;
  // read port: snapshots the whole bank, so same-cycle writes are seen next read
  always_ff @(posedge clk)
    if (rst) rd <= '0;
    else if (en) rd <= mem;
endmodule

// File: rtl/filter_weight_loader.sv
// filter_weight_loader: streams 9 taps + bias into a register bank; FILTER_LOADER_CHECKSUM_EN adds a trailing checksum word
module filter_weight_loader
  import cnn_filter_pkg::*;
#(
  parameter int dataWidthFilter = WEIGHT_W,
  parameter int numWeightFilter = FILTER_WORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic [dataWidthFilter-1:0] s_data,
  output logic                       s_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       weights_valid,
  output logic                       err,
  input  logic                       en,
  output logic [dataWidthFilter-1:0] rdata0,
  output logic [dataWidthFilter-1:0] rdata1,
  output logic [dataWidthFilter-1:0] rdata2,
  output logic [dataWidthFilter-1:0] rdata3,
  output logic [dataWidthFilter-1:0] rdata4,
  output logic [dataWidthFilter-1:0] rdata5,
  output logic [dataWidthFilter-1:0] rdata6,
  output logic [dataWidthFilter-1:0] rdata7,
  output logic [dataWidthFilter-1:0] rdata8,
  output logic [dataWidthFilter-1:0] bias
);
  loader_state_t state;
  logic [3:0] count;
  logic go, xfer, data_word, last, wv_next;
  logic [numWeightFilter-1:0][dataWidthFilter-1:0] rd;
  assign go = state == IDLE && start;
  assign s_ready = state == LOAD;
  assign busy = s_ready;
  assign done = state == DONE;
  assign xfer = s_ready && s_valid;
  assign data_word = xfer && count < 4'(numWeightFilter);
`ifdef FILTER_LOADER_CHECKSUM_EN
  logic [dataWidthFilter-1:0] sum;
  assign last = xfer && count == 4'(numWeightFilter);
  assign wv_next = s_data == sum;
  // running checksum over data words; err is sticky until reset or the next start
  always_ff @(posedge clk)
    if (rst || go) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (data_word) sum <= sum + s_data;
      if (last && !wv_next) err <= 1'b1;
    end
`else
  assign last = xfer && count == 4'(numWeightFilter - 1);
  assign wv_next = 1'b1;
  assign err = 1'b0;
`endif
  // load sequencer: count stops on the final word, so it never wraps
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      weights_valid <= 1'b0;
    end else if (go) begin
      state <= LOAD;
      count <= '0;
      weights_valid <= 1'b0;
    end else if (last) begin
      state <= DONE;
      weights_valid <= wv_next;
    end else if (xfer) count <= count + 4'd1;
    else if (state == DONE) state <= IDLE;
  filter_reg_bank #(.W(dataWidthFilter), .N(numWeightFilter)) u_bank (
    .clk(clk),
    .rst(rst),
    .we(data_word),
    .waddr(count),
    .wdata(s_data),
    .en(en),
    .rd(rd)
  );
  assign rdata0 = rd[0];
  assign rdata1 = rd[1];
  assign rdata2 = rd[2];
  assign rdata3 = rd[3];
  assign rdata4 = rd[4];
  assign rdata5 = rd[5];
  assign rdata6 = rd[6];
  assign rdata7 = rd[7];
  assign rdata8 = rd[8];
  assign bias = rd[NUM_TAPS];
endmodule

// File: tb/tb_filter_weight_loader.sv
// tb_filter_weight_loader: scoreboard bench for filter_weight_loader (FILTER_LOADER_CHECKSUM_EN optional)
module tb_filter_weight_loader;
  typedef logic [9:0][15:0] snap_t;
  logic clk = 0, rst = 1, start = 0, s_valid = 0, en = 0;
  logic [15:0] s_data = '0;
  logic s_ready, busy, done, weights_valid, err;
  logic [15:0] rdata0, rdata1, rdata2, rdata3, rdata4, rdata5, rdata6, rdata7, rdata8, bias;
  snap_t dout, model, w1, w2;
  snap_t sb[$];
  int vectors = 0, miscompares = 0;
  filter_weight_loader dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .busy(busy), .done(done), .weights_valid(weights_valid),
    .err(err), .en(en), .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
    .rdata3(rdata3), .rdata4(rdata4), .rdata5(rdata5), .rdata6(rdata6),
    .rdata7(rdata7), .rdata8(rdata8), .bias(bias)
  );
  always #5 clk = ~clk;
  assign dout = {bias, rdata8, rdata7, rdata6, rdata5, rdata4, rdata3, rdata2, rdata1, rdata0};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic compare_read(input string tag);
    snap_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      for (int k = 0; k < 10; k++) check($sformatf("%s_rd%0d", tag, k), dout[k], e[k]);
    end
  endtask
  task automatic read_check(input string tag);
    en = 1;
    sb.push_back(model);
    tick;
    en = 0;
    compare_read(tag);
  endtask
  task automatic check_zero(input string tag);
    for (int k = 0; k < 10; k++) check($sformatf("%s_rd%0d", tag, k), dout[k], 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wv"}, weights_valid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ready"}, s_ready, 0);
  endtask
  task automatic do_reset(input string tag);
    rst = 1;
    tick;
    check_zero(tag);
    rst = 0;
    model = '0;
  endtask
  task automatic load(input snap_t w, input bit stall, input int restart_at, input bit en_first, input bit bad_cs);
    logic [15:0] sum;
    bit ok;
    start = 1;
    tick;
    start = 0;
    check("ld_busy", busy, 1);
    check("ld_wv_clr", weights_valid, 0);
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      if (stall) begin
        s_valid = 0;
        s_data = 16'hdead;
        tick;
      end
      s_valid = 1;
      s_data = w[i];
      start = (i == restart_at);
      en = en_first && i == 0;
      if (en) sb.push_back(model);
      check($sformatf("ld_ready%0d", i), s_ready, 1);
      check($sformatf("ld_noearly%0d", i), done, 0);
      tick;
      start = 0;
      if (en) begin
        en = 0;
        compare_read("rbw");
      end
      model[i] = w[i];
      sum = sum + w[i];
    end
    ok = 1;
`ifdef FILTER_LOADER_CHECKSUM_EN
    check("ld_cs_wait", done, 0);
    s_data = bad_cs ? ~sum : sum;
    ok = !bad_cs;
    tick;
`endif
    s_valid = 0;
    check("ld_done", done, 1);
    check("ld_busy_off", busy, 0);
    check("ld_wv", weights_valid, ok);
    check("ld_err", err, !ok);
    tick;
    check("ld_done_pulse", done, 0);
    check("ld_wv_hold", weights_valid, ok);
  endtask
  initial begin
    for (int k = 0; k < 9; k++) begin
      w1[k] = 16'(k + 1);
      w2[k] = 16'(16'h1111 * (k + 1) + 16'h0a05);
    end
    w1[9] = 16'h0100;
    w2[9] = 16'hbeef;
    model = '0;
    tick;
    do_reset("reset");
    load(w1, 0, -1, 0, 0);
    read_check("nominal");
    do_reset("reset2");
    load(w1, 1, -1, 0, 0);
    read_check("stall");
    s_valid = 1;
    s_data = 16'hffff;
    for (int k = 0; k < 3; k++) begin
      check("idle_ready", s_ready, 0);
      tick;
    end
    s_valid = 0;
    read_check("idle_ignored");
    load(w2, 0, 4, 0, 0);
    read_check("restart_ignored");
    start = 1;
    tick;
    start = 0;
    s_valid = 1;
    for (int i = 0; i < 5; i++) begin
      s_data = w2[i] ^ 16'h5a5a;
      tick;
    end
    rst = 1;
    en = 1;
    tick;
    en = 0;
    check_zero("midload_rst");
    rst = 0;
    s_valid = 0;
    model = '0;
    tick;
    check("post_rst_idle", busy, 0);
    read_check("post_rst");
    load(w1, 0, -1, 0, 0);
    read_check("reload");
    load(w2, 0, -1, 1, 0);
    read_check("rbw_new");
`ifdef FILTER_LOADER_CHECKSUM_EN
    load(w1, 0, -1, 0, 1);
    read_check("cs_bad");
    load(w1, 0, -1, 0, 0);
    read_check("cs_good");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
